// File: rtl/spdif_playback_ctrl_if.sv
// Handshake bundle between the S/PDIF playback controller and its FIFO / I2S neighbours.
// master = surrounding datapath, slave = spdif_playback_ctrl.
interface spdif_playback_ctrl_if;
  logic       sample_ready;
  logic       spdif_fault;
  logic       next_sample;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_read;
  logic       fifo_flush;
  logic       mute;
  logic [7:0] gain;
  logic [2:0] state;
  logic [7:0] xrun_cnt;

  modport master (
    output sample_ready, spdif_fault, next_sample, fifo_empty, fifo_full,
    input  fifo_read, fifo_flush, mute, gain, state, xrun_cnt
  );

  modport slave (
    input  sample_ready, spdif_fault, next_sample, fifo_empty, fifo_full,
    output fifo_read, fifo_flush, mute, gain, state, xrun_cnt
  );
endinterface

// File: rtl/spdif_playback_ctrl.sv
// S/PDIF -> FIFO -> I2S playback sequencer (clk_384 domain): lock, flush, prime, play, xrun recovery.
// Optional gain ramp enabled by defining SPDIF_PLAYBACK_CTRL_SOFT_MUTE_EN.
module spdif_playback_ctrl #(
  parameter int LOCK_SAMPLES = 64,
  parameter int TIMEOUT      = 4096,
  parameter int PRIME_LEVEL  = 2
`ifdef SPDIF_PLAYBACK_CTRL_SOFT_MUTE_EN
 ,parameter int RAMP_STEP    = 1
`endif
) (
  input logic                  clk,
  input logic                  resetn,
  spdif_playback_ctrl_if.slave bus
);

  localparam int LOCK_W  = $clog2(LOCK_SAMPLES + 1);
  localparam int WD_W    = $clog2(TIMEOUT);
  localparam int PRIME_W = $clog2(PRIME_LEVEL + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOCK  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_PRIME = 3'd3,
    ST_PLAY  = 3'd4
  } state_e;

  state_e               state_r;
  state_e               state_nxt_s;
  logic [LOCK_W-1:0]    lock_cnt_r;
  logic [PRIME_W-1:0]   prime_cnt_r;
  logic [WD_W-1:0]      wd_cnt_r;
  logic                 fifo_flush_r;
  logic                 mute_r;
  logic [7:0]           gain_r;
  logic [7:0]           gain_nxt_s;
  logic [7:0]           xrun_cnt_r;
  logic                 timeout_s;
  logic                 abort_s;
  logic                 xrun_ev_s;
  logic                 lock_done_s;
  logic                 prime_done_s;

  assign timeout_s    = (state_r != ST_IDLE) && (wd_cnt_r == WD_W'(TIMEOUT - 1));
  assign abort_s      = bus.spdif_fault | timeout_s;
  // Overrun and underrun in the same cycle collapse into one event.
  assign xrun_ev_s    = (bus.sample_ready & bus.fifo_full) | (bus.next_sample & bus.fifo_empty);
  assign lock_done_s  = bus.sample_ready && (lock_cnt_r == LOCK_W'(LOCK_SAMPLES - 1));
  assign prime_done_s = bus.fifo_full ||
                        (bus.sample_ready && (prime_cnt_r == PRIME_W'(PRIME_LEVEL - 1)));

  // Next-state logic; fault beats timeout beats overrun/underrun.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (bus.sample_ready && !bus.spdif_fault) state_nxt_s = ST_LOCK;
        else                                      state_nxt_s = ST_IDLE;
      end
      ST_LOCK: begin
        if (abort_s)          state_nxt_s = ST_IDLE;
        else if (lock_done_s) state_nxt_s = ST_FLUSH;
        else                  state_nxt_s = ST_LOCK;
      end
      ST_FLUSH: begin
        if (abort_s) state_nxt_s = ST_IDLE;
        else         state_nxt_s = ST_PRIME;
      end
      ST_PRIME: begin
        if (abort_s)           state_nxt_s = ST_IDLE;
        else if (prime_done_s) state_nxt_s = ST_PLAY;
        else                   state_nxt_s = ST_PRIME;
      end
      ST_PLAY: begin
        if (abort_s)        state_nxt_s = ST_IDLE;
        else if (xrun_ev_s) state_nxt_s = ST_FLUSH;
        else                state_nxt_s = ST_PLAY;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Gain target for the coming cycle, registered alongside the state.
  always_comb begin
    gain_nxt_s = 8'd0;
`ifdef SPDIF_PLAYBACK_CTRL_SOFT_MUTE_EN
    if (state_nxt_s != ST_PLAY || state_r != ST_PLAY) begin
      gain_nxt_s = 8'd0;
    end else if (bus.next_sample) begin
      if ({1'b0, gain_r} + 9'(RAMP_STEP) > 9'd255) gain_nxt_s = 8'd255;
      else                                         gain_nxt_s = gain_r + 8'(RAMP_STEP);
    end else begin
      gain_nxt_s = gain_r;
    end
`else
    if (state_nxt_s == ST_PLAY) gain_nxt_s = 8'd255;
    else                        gain_nxt_s = 8'd0;
`endif
  end

  // State and registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      fifo_flush_r <= 1'b0;
      mute_r       <= 1'b1;
      gain_r       <= 8'd0;
      xrun_cnt_r   <= 8'd0;
    end else begin
      state_r      <= state_nxt_s;
      fifo_flush_r <= (state_nxt_s == ST_FLUSH);
      mute_r       <= (state_nxt_s != ST_PLAY);
      gain_r       <= gain_nxt_s;
      if (state_r == ST_PLAY && !abort_s && xrun_ev_s && xrun_cnt_r != 8'd255)
        xrun_cnt_r <= xrun_cnt_r + 8'd1;
      else
        xrun_cnt_r <= xrun_cnt_r;
    end
  end

  // Lock, prime and watchdog counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_cnt_r  <= '0;
      prime_cnt_r <= '0;
      wd_cnt_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.sample_ready && !bus.spdif_fault) lock_cnt_r <= LOCK_W'(1);
          else                                      lock_cnt_r <= '0;
        end
        ST_LOCK: begin
          if (bus.sample_ready) lock_cnt_r <= lock_cnt_r + LOCK_W'(1);
          else                  lock_cnt_r <= lock_cnt_r;
        end
        default: lock_cnt_r <= '0;
      endcase

      // The FLUSH cycle (and every non-PRIME state) leaves the prime count at zero.
      if (state_r == ST_PRIME && bus.sample_ready) prime_cnt_r <= prime_cnt_r + PRIME_W'(1);
      else if (state_r == ST_PRIME)                prime_cnt_r <= prime_cnt_r;
      else                                         prime_cnt_r <= '0;

      if (state_r == ST_IDLE || bus.sample_ready)  wd_cnt_r <= '0;
      else if (wd_cnt_r != WD_W'(TIMEOUT - 1))     wd_cnt_r <= wd_cnt_r + WD_W'(1);
      else                                         wd_cnt_r <= wd_cnt_r;
    end
  end

  assign bus.fifo_read  = resetn & (state_r == ST_PLAY) & bus.next_sample & ~bus.fifo_empty;
  assign bus.fifo_flush = fifo_flush_r;
  assign bus.mute       = mute_r;
  assign bus.gain       = gain_r;
  assign bus.state      = state_r;
  assign bus.xrun_cnt   = xrun_cnt_r;

endmodule

// File: tb/tb_spdif_playback_ctrl.sv
// Directed self-checking bench for spdif_playback_ctrl (default parameters).
module tb_spdif_playback_ctrl;

`ifdef SPDIF_PLAYBACK_CTRL_SOFT_MUTE_EN
  localparam int GAIN_ENTRY  = 0;
  localparam int GAIN_AFTER1 = 1;
`else
  localparam int GAIN_ENTRY  = 255;
  localparam int GAIN_AFTER1 = 255;
`endif

  logic clk;
  logic resetn;
  int   chk_cnt;
  int   err_cnt;

  spdif_playback_ctrl_if bus_if ();

  spdif_playback_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    bus_if.sample_ready = 1'b1;
    step(1);
    bus_if.sample_ready = 1'b0;
  endtask

  task automatic underrun();
    bus_if.next_sample = 1'b1;
    bus_if.fifo_empty  = 1'b1;
    step(1);
    bus_if.next_sample = 1'b0;
    bus_if.fifo_empty  = 1'b0;
  endtask

  task automatic enter_play(input string tag);
    for (int i = 0; i < 64; i++) begin
      pulse();
      if (i < 63) step(1);
    end
    check({tag, "_flush_state"}, bus_if.state, 2);
    step(1);
    pulse();
    pulse();
    check({tag, "_play_state"}, bus_if.state, 4);
  endtask

  initial begin
    chk_cnt = 0;
    err_cnt = 0;
    resetn  = 1'b0;
    bus_if.sample_ready = 1'b0;
    bus_if.spdif_fault  = 1'b0;
    bus_if.next_sample  = 1'b0;
    bus_if.fifo_empty   = 1'b0;
    bus_if.fifo_full    = 1'b0;
    step(2);
    check("rst_state", bus_if.state, 0);
    check("rst_mute", bus_if.mute, 1);
    check("rst_gain", bus_if.gain, 0);
    check("rst_xrun", bus_if.xrun_cnt, 0);
    check("rst_flush", bus_if.fifo_flush, 0);
    resetn = 1'b1;

    // Slow lock: 64 writes spaced 800 cycles.
    for (int i = 0; i < 64; i++) begin
      pulse();
      if (i == 0)  check("lock_enter", bus_if.state, 1);
      if (i == 62) check("lock_hold63", bus_if.state, 1);
      if (i < 63) step(799);
    end
    check("flush_state", bus_if.state, 2);
    check("flush_hi", bus_if.fifo_flush, 1);
    step(1);
    check("prime_state", bus_if.state, 3);
    check("flush_lo", bus_if.fifo_flush, 0);
    pulse();
    check("prime_hold", bus_if.state, 3);
    pulse();
    check("play_state", bus_if.state, 4);
    check("play_mute", bus_if.mute, 0);
    check("play_gain", bus_if.gain, GAIN_ENTRY);

    // Normal read, then underrun.
    bus_if.next_sample = 1'b1;
    #1;
    check("read_ok", bus_if.fifo_read, 1);
    step(1);
    bus_if.next_sample = 1'b0;
    check("read_state", bus_if.state, 4);
    check("gain_after1", bus_if.gain, GAIN_AFTER1);
    bus_if.next_sample = 1'b1;
    bus_if.fifo_empty  = 1'b1;
    #1;
    check("read_empty", bus_if.fifo_read, 0);
    step(1);
    bus_if.next_sample = 1'b0;
    bus_if.fifo_empty  = 1'b0;
    check("ur_state", bus_if.state, 2);
    check("ur_xrun", bus_if.xrun_cnt, 1);
    check("ur_mute", bus_if.mute, 1);
    check("ur_gain", bus_if.gain, 0);
    step(1);
    check("ur_prime", bus_if.state, 3);
    pulse();
    pulse();
    check("ur_replay", bus_if.state, 4);

    // Overrun with simultaneous read request; write during FLUSH not counted.
    bus_if.sample_ready = 1'b1;
    bus_if.next_sample  = 1'b1;
    bus_if.fifo_full    = 1'b1;
    step(1);
    bus_if.next_sample  = 1'b0;
    bus_if.fifo_full    = 1'b0;
    check("or_state", bus_if.state, 2);
    check("or_xrun", bus_if.xrun_cnt, 2);
    step(1);
    bus_if.sample_ready = 1'b0;
    check("or_prime", bus_if.state, 3);
    pulse();
    check("or_prime_cnt1", bus_if.state, 3);
    pulse();
    check("or_replay", bus_if.state, 4);

    // fifo_full shortcut out of PRIME.
    underrun();
    step(1);
    bus_if.fifo_full = 1'b1;
    step(1);
    bus_if.fifo_full = 1'b0;
    check("full_play", bus_if.state, 4);
    check("full_xrun", bus_if.xrun_cnt, 3);

    // Fault during PRIME.
    underrun();
    step(1);
    pulse();
    check("flt_prime", bus_if.state, 3);
    bus_if.spdif_fault = 1'b1;
    step(1);
    check("flt_state", bus_if.state, 0);
    check("flt_mute", bus_if.mute, 1);
    check("flt_gain", bus_if.gain, 0);
    bus_if.sample_ready = 1'b1;
    step(1);
    bus_if.sample_ready = 1'b0;
    bus_if.spdif_fault  = 1'b0;
    check("flt_nolock", bus_if.state, 0);

    // Watchdog timeout in PLAY.
    enter_play("to");
    step(4095);
    check("to_before", bus_if.state, 4);
    step(1);
    check("to_state", bus_if.state, 0);
    check("to_mute", bus_if.mute, 1);
    check("to_gain", bus_if.gain, 0);

    // Saturating xrun counter.
    enter_play("sat");
    for (int i = 0; i < 300; i++) begin
      underrun();
      step(1);
      pulse();
      pulse();
    end
    check("sat_xrun", bus_if.xrun_cnt, 255);
    check("sat_state", bus_if.state, 4);

`ifdef SPDIF_PLAYBACK_CTRL_SOFT_MUTE_EN
    bus_if.next_sample = 1'b1;
    step(10);
    check("ramp_10", bus_if.gain, 10);
    step(250);
    bus_if.next_sample = 1'b0;
    check("ramp_sat", bus_if.gain, 255);
    pulse();
`endif

    // Asynchronous reset mid-PLAY.
    bus_if.next_sample = 1'b1;
    #1;
    check("ar_read_pre", bus_if.fifo_read, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_state", bus_if.state, 0);
    check("ar_mute", bus_if.mute, 1);
    check("ar_gain", bus_if.gain, 0);
    check("ar_xrun", bus_if.xrun_cnt, 0);
    check("ar_flush", bus_if.fifo_flush, 0);
    check("ar_read", bus_if.fifo_read, 0);
    bus_if.next_sample = 1'b0;
    step(2);
    resetn = 1'b1;
    step(1);
    check("ar_after", bus_if.state, 0);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/spdif_playback_ctrl.md
Name: spdif_playback_ctrl

Overview:
- Sequences the S/PDIF→FIFO→I2S playback path in the clk_384 domain.
- Qualifies the S/PDIF stream, flushes the 3-entry FIFO, and pre-fills (primes) it before playback.
- Gates I2S reads from the FIFO and recovers from overrun/underrun by re-flushing and re-priming.
- Drives mute/gain and status for the LED logic.

Parameters:
- LOCK_SAMPLES, 64, consecutive sample_ready strobes without fault needed to leave LOCK.
- TIMEOUT, 4096, clk cycles without sample_ready treated as stream loss.
- PRIME_LEVEL, 2, FIFO writes after flush before PLAY is entered (1..3).
- RAMP_STEP, 1, gain increment per next_sample (SOFT_MUTE_EN only).

Ports:
- clk  in  1  clk_384 domain clock
- resetn  in  1  asynchronous active-low reset
- sample_ready  in  1  one-cycle strobe: FIFO write occurring this cycle
- spdif_fault  in  1  decoder fault level
- next_sample  in  1  one-cycle strobe from I2S transmitter requesting a sample
- fifo_empty  in  1  FIFO empty flag
- fifo_full  in  1  FIFO full flag
- fifo_read  out  1  gated FIFO read strobe
- fifo_flush  out  1  one-cycle synchronous FIFO clear request, active high
- mute  out  1  1 = output must be zeroed
- gain  out  8  output gain, 255 = unity
- state  out  3  current state encoding
- xrun_cnt  out  8  saturating overrun+underrun count

Behaviour:
- Reset (resetn low, asynchronous, any time including mid-PLAY): state=IDLE, fifo_flush=0, mute=1, gain=0, xrun_cnt=0, all counters 0.
- fifo_read is combinational and forced 0 during reset.
- State encodings: IDLE=0, LOCK=1, FLUSH=2, PRIME=3, PLAY=4; codes 5–7 recover to IDLE on the next clk.
- Watchdog: counter cleared on sample_ready, otherwise increments, saturating. timeout = counter reaches TIMEOUT-1. Active in every state except IDLE.
- Event priority, evaluated each cycle: spdif_fault > timeout > overrun > underrun.
- spdif_fault=1 or timeout in any non-IDLE state → IDLE next cycle.
- IDLE: lock counter=0. On sample_ready with spdif_fault=0 → LOCK, lock counter=1.
- LOCK: each sample_ready increments the lock counter. When the count reaches LOCK_SAMPLES → FLUSH.
- FLUSH: lasts exactly 1 cycle.
  - fifo_flush=1 (registered, asserted during the FLUSH cycle); prime counter cleared.
  - → PRIME. A sample_ready in the FLUSH cycle is not counted.
- PRIME: each sample_ready increments the prime counter. When the count reaches PRIME_LEVEL, or fifo_full=1 → PLAY.
- PLAY:
  - fifo_read = next_sample & !fifo_empty.
  - Overrun = sample_ready & fifo_full → FLUSH, xrun_cnt+1.
  - Underrun = next_sample & fifo_empty → FLUSH, xrun_cnt+1, fifo_read=0.
  - Both in the same cycle: counted once.
- fifo_read=0 in all states other than PLAY.
- xrun_cnt saturates at 255 and is never cleared except by reset.
- mute = (state != PLAY), registered: changes on the same edge as state.

Optional Feature:
- Macro: SPDIF_PLAYBACK_CTRL_SOFT_MUTE_EN.
- Defined:
  - In PLAY, gain increments by RAMP_STEP on each next_sample, saturating at 255.
  - Gain starts at 0 on entering PLAY.
  - Leaving PLAY sets gain=0 on the transition edge.
- Undefined: gain = 255 in PLAY, else 0, registered with state.

Test Plan:
- Reset released, then 64 sample_ready pulses spaced 800 cycles, no fault → state 0→1→2 (fifo_flush high exactly 1 cycle) →3; 2 further writes → state=4, mute=0.
- In PLAY, next_sample with fifo_empty=0 → fifo_read=1 the same cycle. next_sample with fifo_empty=1 → fifo_read=0, xrun_cnt=1, state=2 next cycle, then 3.
- In PLAY, sample_ready and next_sample asserted together with fifo_full=1 → single xrun increment, FLUSH.
- spdif_fault raised in PRIME, and separately stream stopped for 4096 cycles in PLAY → state=0, mute=1, gain=0.
- 300 forced underruns → xrun_cnt holds 255. resetn pulsed low mid-PLAY → all outputs return to reset values asynchronously.
- With SOFT_MUTE_EN, RAMP_STEP=1 → gain 0,1,2… per next_sample after entering PLAY, holds 255 after 255 samples. Without the macro → gain=255 on entering PLAY.
